// File: rtl/demux_reg_hs.sv
// Registered 1-to-N demultiplexer with valid/ready handshakes, per-channel hold
// registers, broadcast mode and a sticky out-of-range select flag.
module demux_reg_hs #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  input  logic                      err_clr,
  output logic                      err_sel
);

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] drain;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] load;
  logic                in_range;
  logic                accept;
  logic                oor;

  // Handshake decode; a one-hot select keeps out-of-range indices from touching any channel.
  always_comb begin
    free    = ~out_valid | out_ready;
    drain   = out_valid & out_ready;
    sel_hit = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      sel_hit[c] = (32'(in_sel) == c);
    end
    in_range = |sel_hit;
    if (in_bcast) begin
      in_ready = &free;
    end else if (in_range) begin
      in_ready = |(sel_hit & free);
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid & in_ready;
    load   = '0;
    if (accept) begin
      load = in_bcast ? {CHANNELS{1'b1}} : sel_hit;
    end
    oor = accept & ~in_bcast & ~in_range;
  end

  // Channel registers: load wins over drain, data holds after drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      err_sel   <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (load[c]) begin
          out_data[c*WIDTH +: WIDTH] <= in_data;
          out_valid[c]               <= 1'b1;
        end else if (drain[c]) begin
          out_valid[c] <= 1'b0;
        end
      end
      if (oor) begin
        err_sel <= 1'b1;
      end else if (err_clr) begin
        err_sel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_reg_hs.sv
// Directed bench for demux_reg_hs: an 8-channel instance with a drain scoreboard
// and a 6-channel instance for out-of-range selects.
module tb_demux_reg_hs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_bcast, in_valid, in_ready, err_clr, err_sel;
  logic [127:0] out_data;
  logic [7:0]   out_valid, out_ready;

  logic [15:0]  b_data;
  logic [2:0]   b_sel;
  logic         b_bcast, b_valid, b_ready, b_err_clr, b_err;
  logic [95:0]  b_out_data;
  logic [5:0]   b_out_valid, b_out_ready;

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] d;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_reg_hs u8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_clr(err_clr), .err_sel(err_sel)
  );

  demux_reg_hs #(.WIDTH(16), .CHANNELS(6), .SEL_W(3)) u6 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
    .in_valid(b_valid), .in_ready(b_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .err_clr(b_err_clr), .err_sel(b_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic b,
                       input logic [15:0] d, input logic [7:0] r);
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_bcast  = b;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic push(input logic [2:0] ch, input logic [15:0] d);
    exp_q.push_back('{ch: ch, d: d});
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every drain on the 8-channel instance must match the oldest expected word for that channel.
  always begin
    @(negedge clk);
    #3;
    if (rst_n === 1'b1) begin
      for (int c = 0; c < 8; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].ch == 3'(c)) idx = i;
          end
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL drain_unexpected ch%0d: got %0h expected none", c, out_data[c*16 +: 16]);
          end else begin
            if (out_data[c*16 +: 16] !== exp_q[idx].d) begin
              errors++;
              $display("FAIL drain_data ch%0d: got %0h expected %0h", c, out_data[c*16 +: 16], exp_q[idx].d);
            end
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; err_clr = 1'b0;
    in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0; out_ready = '0;
    b_valid = 1'b0; b_sel = '0; b_bcast = 1'b0; b_data = '0; b_out_ready = '0; b_err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("reset_valid", 128'(out_valid), 128'h0);
    chk("reset_data", out_data, 128'h0);
    chk("reset_err", 128'(err_sel), 128'h0);
    chk("reset_b_err", 128'(b_err), 128'h0);

    // Unicast, then drain with hold
    drive(1'b1, 3'd3, 1'b0, 16'hA5A5, 8'h00); #1;
    chk("uni_ready", 128'(in_ready), 128'h1);
    push(3'd3, 16'hA5A5);
    after_edge();
    chk("uni_valid", 128'(out_valid), 128'h08);
    chk("uni_data", 128'(out_data[48 +: 16]), 128'hA5A5);
    drive(1'b0, 3'd0, 1'b0, 16'h0, 8'h08);
    after_edge();
    chk("drain_valid", 128'(out_valid), 128'h00);
    chk("hold_data", 128'(out_data[48 +: 16]), 128'hA5A5);

    // Back-pressure on channel 3, channel 5 unaffected
    drive(1'b1, 3'd3, 1'b0, 16'h1111, 8'h00);
    push(3'd3, 16'h1111);
    after_edge();
    drive(1'b1, 3'd3, 1'b0, 16'h2222, 8'h00); #1;
    chk("bp_ready_ch3", 128'(in_ready), 128'h0);
    in_sel = 3'd5; in_data = 16'h5555; #1;
    chk("bp_ready_ch5", 128'(in_ready), 128'h1);
    push(3'd5, 16'h5555);
    after_edge();
    chk("bp_valid", 128'(out_valid), 128'h28);
    chk("bp_ch3_kept", 128'(out_data[48 +: 16]), 128'h1111);
    chk("bp_ch5_data", 128'(out_data[80 +: 16]), 128'h5555);
    drive(1'b0, 3'd0, 1'b0, 16'h0, 8'h28);
    after_edge();
    chk("bp_drained", 128'(out_valid), 128'h00);

    // Streaming into channel 2 at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 3'd2, 1'b0, 16'(i), 8'h04); #1;
      chk("stream_ready", 128'(in_ready), 128'h1);
      push(3'd2, 16'(i));
      after_edge();
      chk("stream_valid2", 128'(out_valid[2]), 128'h1);
      chk("stream_data2", 128'(out_data[32 +: 16]), 128'(i));
    end
    drive(1'b0, 3'd0, 1'b0, 16'h0, 8'h04);
    after_edge();
    chk("stream_end", 128'(out_valid), 128'h00);

    // Broadcast blocked by channel 6, then released
    drive(1'b1, 3'd6, 1'b0, 16'h6666, 8'h00);
    push(3'd6, 16'h6666);
    after_edge();
    drive(1'b1, 3'd0, 1'b1, 16'h0F0F, 8'h00); #1;
    chk("bc_blocked", 128'(in_ready), 128'h0);
    after_edge();
    chk("bc_hold_valid", 128'(out_valid), 128'h40);
    drive(1'b1, 3'd0, 1'b1, 16'h0F0F, 8'h40); #1;
    chk("bc_ready", 128'(in_ready), 128'h1);
    for (int c = 0; c < 8; c++) push(3'(c), 16'h0F0F);
    after_edge();
    chk("bc_valid", 128'(out_valid), 128'hFF);
    chk("bc_data", out_data, {8{16'h0F0F}});
    drive(1'b0, 3'd0, 1'b0, 16'h0, 8'hFF);
    after_edge();
    chk("bc_drained", 128'(out_valid), 128'h00);

    // Out-of-range select on the 6-channel instance
    @(negedge clk);
    b_valid = 1'b1; b_sel = 3'd2; b_data = 16'h2222;
    after_edge();
    @(negedge clk);
    b_sel = 3'd7; b_data = 16'hBEEF; #1;
    chk("oor_ready", 128'(b_ready), 128'h1);
    after_edge();
    chk("oor_err", 128'(b_err), 128'h1);
    chk("oor_valid", 128'(b_out_valid), 128'h04);
    chk("oor_data2", 128'(b_out_data[32 +: 16]), 128'h2222);
    @(negedge clk);
    b_err_clr = 1'b1;
    after_edge();
    chk("oor_set_prio", 128'(b_err), 128'h1);
    @(negedge clk);
    b_valid = 1'b0;
    after_edge();
    chk("oor_clear", 128'(b_err), 128'h0);
    @(negedge clk);
    b_err_clr = 1'b0; b_valid = 1'b1; b_sel = 3'd6;
    after_edge();
    chk("oor_sel6", 128'(b_err), 128'h1);
    @(negedge clk);
    b_valid = 1'b0;

    // Reset mid-operation discards in-flight and held words
    drive(1'b1, 3'd0, 1'b0, 16'h0A0A, 8'h00);
    after_edge();
    drive(1'b1, 3'd4, 1'b0, 16'h4A4A, 8'h00);
    after_edge();
    chk("pre_rst_valid", 128'(out_valid), 128'h11);
    drive(1'b1, 3'd1, 1'b0, 16'h1B1B, 8'h00);
    rst_n = 1'b0;
    after_edge();
    exp_q.delete();
    chk("rst_valid", 128'(out_valid), 128'h00);
    chk("rst_data", out_data, 128'h0);
    chk("rst_err", 128'(err_sel), 128'h0);
    chk("rst_b_err", 128'(b_err), 128'h0);
    chk("rst_b_valid", 128'(b_out_valid), 128'h00);
    drive(1'b0, 3'd0, 1'b0, 16'h0, 8'h00);
    rst_n = 1'b1;
    after_edge();
    chk("post_rst_valid", 128'(out_valid), 128'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
